// File: rtl/ascon_permutation_core.sv
// Iterative ASCON p^a permutation: one round (constant add, S-box, linear layer)
// per clock over the 320-bit state, with a start/busy/done handshake.
module ascon_permutation_core #(
  parameter int STATE_W = 320,
  parameter int CTR_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CTR_W-1:0]   rounds,
  input  logic [STATE_W-1:0] state_in,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [STATE_W-1:0] state_out,
  output logic [CTR_W-1:0]   ctr_out
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fsm_t;

  fsm_t               fsm, fsm_next;
  logic [STATE_W-1:0] state_p1;
  logic [CTR_W-1:0]   ctr_p1;
  logic [CTR_W-1:0]   rounds_p1;
  logic [STATE_W-1:0] round_out;
  logic               legal, load, reject, last;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Constants count down by 0x0F per round so every length ends on 0x4B.
  function automatic logic [7:0] round_const(input logic [CTR_W-1:0] r,
                                             input logic [CTR_W-1:0] c);
    logic [7:0] base;
    case (r)
      CTR_W'(6): base = 8'h96;
      CTR_W'(8): base = 8'hB4;
      default:   base = 8'hF0;
    endcase
    return base - (8'(c) * 8'd15);
  endfunction

  function automatic logic [STATE_W-1:0] ascon_round(input logic [STATE_W-1:0] s,
                                                     input logic [7:0] rc);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    x2 = x2 ^ {56'b0, rc};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  assign legal     = (rounds == CTR_W'(6)) || (rounds == CTR_W'(8)) ||
                     (rounds == CTR_W'(12));
  assign last      = (fsm == RUN) && (ctr_p1 == rounds_p1 - 1'b1);
  assign round_out = ascon_round(state_p1, round_const(rounds_p1, ctr_p1));
  assign ctr_out   = ctr_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE:    if (start && legal) fsm_next = RUN;
      RUN:     if (last)           fsm_next = IDLE;
      default:                     fsm_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (fsm == RUN);
    load   = (fsm == IDLE) && start && legal;
    reject = (fsm == IDLE) && start && !legal;
  end

  // Round register: loaded on accept, advanced once per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1  <= '0;
      ctr_p1    <= '0;
      rounds_p1 <= '0;
      state_out <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= reject;
      if (load) begin
        state_p1  <= state_in;
        rounds_p1 <= rounds;
        ctr_p1    <= '0;
      end else if (busy) begin
        state_p1 <= round_out;
        if (last) begin
          state_out <= round_out;
          done      <= 1'b1;
          ctr_p1    <= '0;
        end else begin
          ctr_p1 <= ctr_p1 + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ascon_permutation_core.sv
// Bench for ascon_permutation_core: table vectors, random 6/8-round states,
// back-to-back, illegal rounds and mid-run reset against a lookup-table model.
module tb_ascon_permutation_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [4:0]   rounds;
  logic [319:0] state_in;
  logic         busy, done, err;
  logic [319:0] state_out;
  logic [4:0]   ctr_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  ascon_permutation_core dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rounds(rounds),
    .state_in(state_in), .busy(busy), .done(done), .err(err),
    .state_out(state_out), .ctr_out(ctr_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ASCON S-box as a 32-entry table, x0 is the index MSB
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // p^a uses the last a constants of p^12; constant i is ((15-i)<<4)|i
  function automatic logic [319:0] model_perm(input logic [319:0] s, input int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col, o;
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    for (int rd = 12 - r; rd < 12; rd++) begin
      x[2] = x[2] ^ 64'(((15 - rd) << 4) | rd);
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o = SBOX[col];
        for (int i = 0; i < 5; i++) y[i][b] = o[4 - i];
      end
      for (int i = 0; i < 5; i++) x[i] = y[i] ^ ror(y[i], ROT_A[i]) ^ ror(y[i], ROT_B[i]);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] v = '0;
    for (int i = 0; i < 10; i++) v = {v[287:0], 32'($urandom)};
    return v;
  endfunction

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_perm(input logic [4:0] r, input logic [319:0] s,
                         input bit legal, input string tag);
    logic [319:0] prev;
    int lat, bcnt;
    bit ctr_ok;
    prev = state_out;
    start = 1'b1; rounds = r; state_in = s;
    step();
    start = 1'b0; rounds = 5'($urandom); state_in = rand320();
    if (!legal) begin
      check({tag, " err_pulse"}, {err, busy, done}, 320'b100);
      step();
      check({tag, " err_clear"}, {err, busy, done}, 320'b000);
      check({tag, " out_kept"}, state_out, prev);
      return;
    end
    check({tag, " accept"}, {err, busy, done}, 320'b010);
    lat = 0; bcnt = busy ? 1 : 0; ctr_ok = (ctr_out == 5'd0);
    while (!done && lat < 40) begin
      step();
      lat++;
      if (busy) begin
        bcnt++;
        if (ctr_out != 5'(lat)) ctr_ok = 1'b0;
      end
    end
    check({tag, " latency"}, 320'(lat), 320'(r));
    check({tag, " busy_cycles"}, 320'(bcnt), 320'(r));
    check({tag, " ctr_seq"}, 320'(ctr_ok), 320'd1);
    check({tag, " state_out"}, state_out, model_perm(s, int'(r)));
    step();
    check({tag, " done_pulse"}, {done, busy}, 320'b00);
  endtask

  typedef struct {
    logic [4:0] rounds;
    bit         legal;
    logic [2:0] exp_flags_after_accept;  // {err, busy, done}
  } vec_t;

  vec_t tbl [10];

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [319:0] s1, s2;
    int c1, n;

    tbl[0] = '{5'd12, 1'b1, 3'b010};
    tbl[1] = '{5'd6,  1'b1, 3'b010};
    tbl[2] = '{5'd8,  1'b1, 3'b010};
    tbl[3] = '{5'd0,  1'b0, 3'b100};
    tbl[4] = '{5'd5,  1'b0, 3'b100};
    tbl[5] = '{5'd7,  1'b0, 3'b100};
    tbl[6] = '{5'd31, 1'b0, 3'b100};
    tbl[7] = '{5'd6,  1'b1, 3'b010};
    tbl[8] = '{5'd13, 1'b0, 3'b100};
    tbl[9] = '{5'd8,  1'b1, 3'b010};

    rst_n = 1'b0; start = 1'b0; rounds = '0; state_in = '0;
    repeat (3) step();
    check("reset outputs", {busy, done, err, ctr_out, state_out}, '0);
    rst_n = 1'b1;
    step();

    // IV-style init, then all-zero and all-ones states
    do_perm(5'd12, {64'h80400C0600000000, 256'b0}, 1'b1, "iv_init");
    do_perm(5'd12, '0, 1'b1, "all_zero");
    do_perm(5'd12, '1, 1'b1, "all_ones");

    for (int i = 0; i < 10; i++) begin
      s1 = state_out;
      start = 1'b1; rounds = tbl[i].rounds; state_in = rand320();
      s2 = state_in;
      step();
      start = 1'b0;
      check($sformatf("tbl%0d flags", i), {err, busy, done}, 320'(tbl[i].exp_flags_after_accept));
      n = 0;
      while (busy && n < 40) begin step(); n++; end
      if (tbl[i].legal) begin
        check($sformatf("tbl%0d result", i), state_out, model_perm(s2, int'(tbl[i].rounds)));
        check($sformatf("tbl%0d latency", i), 320'(n), 320'(tbl[i].rounds));
      end else begin
        step();
        check($sformatf("tbl%0d out_kept", i), state_out, s1);
      end
      step();
    end

    for (int i = 0; i < 1000; i++) do_perm(5'd6, rand320(), 1'b1, "rand6");
    for (int i = 0; i < 1000; i++) do_perm(5'd8, rand320(), 1'b1, "rand8");

    // Back-to-back: second start in the done cycle; start during RUN ignored
    s1 = rand320(); s2 = rand320();
    start = 1'b1; rounds = 5'd12; state_in = s1;
    step();
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin step(); n++; end
    c1 = cyc;
    check("b2b first", state_out, model_perm(s1, 12));
    start = 1'b1; rounds = 5'd6; state_in = s2;
    step();
    check("b2b accept", 320'(busy), 320'd1);
    rounds = 5'd12; state_in = rand320();
    step();
    step();
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin step(); n++; end
    check("b2b spacing", 320'(cyc - c1), 320'd7);
    check("b2b second", state_out, model_perm(s2, 6));
    step();
    check("b2b no_queue", {busy, done}, 320'b00);

    // Reset while round 5 of 12 is in flight
    start = 1'b1; rounds = 5'd12; state_in = rand320();
    step();
    start = 1'b0;
    n = 0;
    while (ctr_out != 5'd5 && n < 40) begin step(); n++; end
    check("midrst reached", 320'(ctr_out), 320'd5);
    rst_n = 1'b0;
    #1;
    check("midrst async", {busy, done, err, ctr_out, state_out}, '0);
    n = 0;
    repeat (14) begin step(); if (done) n++; end
    check("midrst no_done", 320'(n), 320'd0);
    rst_n = 1'b1;
    step();
    do_perm(5'd12, rand320(), 1'b1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
